// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
//   Architectural register file with per-register rename tags. It sits between
//   the reorder buffer commit port and the instruction issuer.
//
//   The issuer reads two sources per cycle. For each source it gets either a
//   ready value (q == 0) or the ROB id of the in-flight producer (q != 0). The
//   issuer also renames the destination register to its freshly allocated ROB
//   id. The ROB commits values back. A commit clears the register's tag only
//   when the tag still names the committing entry. A ROB-bus flush clears every
//   tag. x0 is hardwired to zero and carries no tag.
//
// Ports
//   i_clk                 clock, all state updates on the rising edge
//   i_rst                 synchronous active-high reset, beats everything
//   i_rdy                 global enable, state holds while low
//   i_valid_from_issuer   issuer dispatches one instruction this cycle
//   i_rd_from_issuer      destination register of the dispatched instruction
//   i_dest_from_issuer    ROB id allocated to the dispatched instruction
//   i_rs1_from_issuer     source register 1 index
//   i_rs2_from_issuer     source register 2 index
//   o_qj_to_issuer        producer tag for rs1, 0 means ready
//   o_vj_to_issuer        value for rs1, meaningful when qj == 0
//   o_qk_to_issuer        producer tag for rs2, 0 means ready
//   o_vk_to_issuer        value for rs2, meaningful when qk == 0
//   i_dest_from_rob       committing ROB id, 0 means no commit
//   i_rd_from_rob         commit destination register
//   i_value_from_rob      commit value
//   i_reset_from_rob_bus  misprediction flush, clears all tags
// ----------------------------------------------------------------------------
module reg_file #(
  parameter int REG_COUNT    = 32,
  parameter int REG_ID_WIDTH = 5,
  parameter int REG_WIDTH    = 32,
  parameter int ROB_ID_WIDTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_rdy,

  input  logic                    i_valid_from_issuer,
  input  logic [REG_ID_WIDTH-1:0] i_rd_from_issuer,
  input  logic [ROB_ID_WIDTH-1:0] i_dest_from_issuer,
  input  logic [REG_ID_WIDTH-1:0] i_rs1_from_issuer,
  input  logic [REG_ID_WIDTH-1:0] i_rs2_from_issuer,

  output logic [ROB_ID_WIDTH-1:0] o_qj_to_issuer,
  output logic [REG_WIDTH-1:0]    o_vj_to_issuer,
  output logic [ROB_ID_WIDTH-1:0] o_qk_to_issuer,
  output logic [REG_WIDTH-1:0]    o_vk_to_issuer,

  input  logic [ROB_ID_WIDTH-1:0] i_dest_from_rob,
  input  logic [REG_ID_WIDTH-1:0] i_rd_from_rob,
  input  logic [REG_WIDTH-1:0]    i_value_from_rob,
  input  logic                    i_reset_from_rob_bus
);

  typedef struct packed {
    logic [ROB_ID_WIDTH-1:0] q;
    logic [REG_WIDTH-1:0]    v;
  } rd_port_t;

  logic [REG_WIDTH-1:0]    r_value [REG_COUNT];
  logic [ROB_ID_WIDTH-1:0] r_tag   [REG_COUNT];

  logic     w_commit;
  logic     w_rename;
  rd_port_t w_rs1;
  rd_port_t w_rs2;

  // A commit to x0 is a no-op. A rename is dropped when the same cycle flushes.
  assign w_commit = (i_dest_from_rob != '0) && (i_rd_from_rob != '0);
  assign w_rename = i_valid_from_issuer && (i_rd_from_issuer != '0) &&
                    !i_reset_from_rob_bus;

  // Read path sees pre-edge state. A commit that retires the very producer the
  // source is waiting on is forwarded straight through. This happens even while
  // i_rdy is low.
  function automatic rd_port_t f_read(input logic [REG_ID_WIDTH-1:0] rs);
    rd_port_t res;
    res = '0;
    if (rs != '0) begin
      if ((r_tag[rs] != '0) && w_commit && (i_dest_from_rob == r_tag[rs]) &&
          (i_rd_from_rob == rs)) begin
        res.q = '0;
        res.v = i_value_from_rob;
      end else begin
        res.q = r_tag[rs];
        res.v = r_value[rs];
      end
    end
    return res;
  endfunction

  always_comb begin
    w_rs1 = f_read(i_rs1_from_issuer);
    w_rs2 = f_read(i_rs2_from_issuer);
  end

  assign o_qj_to_issuer = w_rs1.q;
  assign o_vj_to_issuer = w_rs1.v;
  assign o_qk_to_issuer = w_rs2.q;
  assign o_vk_to_issuer = w_rs2.v;

  // Entry 0 is cleared by reset and never written afterwards. Reads of x0 are
  // also forced to zero in f_read.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_value[i] <= '0;
        r_tag[i]   <= '0;
      end
    end else if (i_rdy) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        // The value always lands, even under a flush. The flushing branch or
        // jalr commits in the same cycle, and its link register must be kept.
        if (w_commit && (i_rd_from_rob == REG_ID_WIDTH'(i)))
          r_value[i] <= i_value_from_rob;

        // Tag priority: flush, then rename, then matching-commit clear.
        // A mismatching tag on commit means a younger producer owns the
        // register, so that tag is kept.
        if (i_reset_from_rob_bus)
          r_tag[i] <= '0;
        else if (w_rename && (i_rd_from_issuer == REG_ID_WIDTH'(i)))
          r_tag[i] <= i_dest_from_issuer;
        else if (w_commit && (i_rd_from_rob == REG_ID_WIDTH'(i)) &&
                 (r_tag[i] == i_dest_from_rob))
          r_tag[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

  localparam int RIW = 5;
  localparam int RW  = 32;
  localparam int BW  = 4;

  logic           clk;
  logic           rst;
  logic           rdy;
  logic           valid_iss;
  logic [RIW-1:0] rd_iss;
  logic [BW-1:0]  dest_iss;
  logic [RIW-1:0] rs1;
  logic [RIW-1:0] rs2;
  logic [BW-1:0]  qj;
  logic [RW-1:0]  vj;
  logic [BW-1:0]  qk;
  logic [RW-1:0]  vk;
  logic [BW-1:0]  dest_rob;
  logic [RIW-1:0] rd_rob;
  logic [RW-1:0]  val_rob;
  logic           flush;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string         name;
    logic [BW-1:0] qj;
    logic [RW-1:0] vj;
    logic [BW-1:0] qk;
    logic [RW-1:0] vk;
  } exp_t;

  exp_t sb[$];

  reg_file dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_rdy                (rdy),
    .i_valid_from_issuer  (valid_iss),
    .i_rd_from_issuer     (rd_iss),
    .i_dest_from_issuer   (dest_iss),
    .i_rs1_from_issuer    (rs1),
    .i_rs2_from_issuer    (rs2),
    .o_qj_to_issuer       (qj),
    .o_vj_to_issuer       (vj),
    .o_qk_to_issuer       (qk),
    .o_vk_to_issuer       (vk),
    .i_dest_from_rob      (dest_rob),
    .i_rd_from_rob        (rd_rob),
    .i_value_from_rob     (val_rob),
    .i_reset_from_rob_bus (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    rst       = 1'b0;
    rdy       = 1'b1;
    valid_iss = 1'b0;
    rd_iss    = '0;
    dest_iss  = '0;
    rs1       = '0;
    rs2       = '0;
    dest_rob  = '0;
    rd_rob    = '0;
    val_rob   = '0;
    flush     = 1'b0;
  endtask

  // Inputs for the cycle are already driven. Push the expected reads, sample
  // mid-cycle, compare, then step past the edge and return inputs to idle.
  task automatic cyc(input string name, input logic [BW-1:0] eqj,
                     input logic [RW-1:0] evj, input logic [BW-1:0] eqk,
                     input logic [RW-1:0] evk);
    exp_t e;
    e.name = name; e.qj = eqj; e.vj = evj; e.qk = eqk; e.vk = evk;
    sb.push_back(e);
    #4;
    e = sb.pop_front();
    n_cmp++;
    assert (qj === e.qj) else begin
      n_bad++;
      $error("FAIL %s.qj observed=%0h expected=%0h", e.name, qj, e.qj);
    end
    n_cmp++;
    assert (vj === e.vj) else begin
      n_bad++;
      $error("FAIL %s.vj observed=%0h expected=%0h", e.name, vj, e.vj);
    end
    n_cmp++;
    assert (qk === e.qk) else begin
      n_bad++;
      $error("FAIL %s.qk observed=%0h expected=%0h", e.name, qk, e.qk);
    end
    n_cmp++;
    assert (vk === e.vk) else begin
      n_bad++;
      $error("FAIL %s.vk observed=%0h expected=%0h", e.name, vk, e.vk);
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle();

    rs1 = 5; rs2 = 0;
    cyc("reset", 4'd0, 32'h0, 4'd0, 32'h0);

    dest_rob = 1; rd_rob = 0; val_rob = 32'hDEAD;
    cyc("x0_commit", 4'd0, 32'h0, 4'd0, 32'h0);

    valid_iss = 1; rd_iss = 3; dest_iss = 4; rs1 = 3; rs2 = 5;
    cyc("ren_x3", 4'd0, 32'h0, 4'd0, 32'h0);

    rs1 = 3; rs2 = 3;
    cyc("x3_tagged", 4'd4, 32'h0, 4'd4, 32'h0);

    dest_rob = 4; rd_rob = 3; val_rob = 32'h1234; rs1 = 3; rs2 = 3;
    cyc("x3_bypass", 4'd0, 32'h1234, 4'd0, 32'h1234);

    rs1 = 3; rs2 = 5;
    cyc("x3_committed", 4'd0, 32'h1234, 4'd0, 32'h0);

    valid_iss = 1; rd_iss = 7; dest_iss = 2; rs1 = 7;
    cyc("ren_x7_a", 4'd0, 32'h0, 4'd0, 32'h0);

    valid_iss = 1; rd_iss = 7; dest_iss = 5; rs1 = 7;
    cyc("ren_x7_b", 4'd2, 32'h0, 4'd0, 32'h0);

    dest_rob = 2; rd_rob = 7; val_rob = 9; rs1 = 7; rs2 = 3;
    cyc("x7_stale_commit", 4'd5, 32'h0, 4'd0, 32'h1234);

    rs1 = 7;
    cyc("x7_keeps_tag", 4'd5, 32'h9, 4'd0, 32'h0);

    valid_iss = 1; rd_iss = 8; dest_iss = 3; rs1 = 8;
    cyc("ren_x8_a", 4'd0, 32'h0, 4'd0, 32'h0);

    valid_iss = 1; rd_iss = 8; dest_iss = 6;
    dest_rob = 3; rd_rob = 8; val_rob = 32'hABC; rs1 = 8; rs2 = 7;
    cyc("x8_ren_commit", 4'd0, 32'hABC, 4'd5, 32'h9);

    rs1 = 8;
    cyc("x8_rename_wins", 4'd6, 32'hABC, 4'd0, 32'h0);

    dest_rob = 1; rd_rob = 1; val_rob = 7; rs1 = 1;
    cyc("x1_write", 4'd0, 32'h0, 4'd0, 32'h0);

    valid_iss = 1; rd_iss = 1; dest_iss = 9; rs1 = 1;
    cyc("self_dep_old", 4'd0, 32'h7, 4'd0, 32'h0);

    rs1 = 1;
    cyc("self_dep_new", 4'd9, 32'h7, 4'd0, 32'h0);

    valid_iss = 1; rd_iss = 2; dest_iss = 7; rs1 = 2; rs2 = 10;
    cyc("ren_x2", 4'd0, 32'h0, 4'd0, 32'h0);

    valid_iss = 1; rd_iss = 10; dest_iss = 11; rs1 = 2; rs2 = 10;
    cyc("ren_x10", 4'd7, 32'h0, 4'd0, 32'h0);

    // Flush while stalled: bypass is still visible, nothing else changes.
    rdy = 0; flush = 1; dest_rob = 11; rd_rob = 10; val_rob = 32'h55;
    valid_iss = 1; rd_iss = 4; dest_iss = 3; rs1 = 10; rs2 = 4;
    cyc("flush_stalled", 4'd0, 32'h55, 4'd0, 32'h0);

    rs1 = 10; rs2 = 4;
    cyc("after_stall", 4'd11, 32'h0, 4'd0, 32'h0);

    flush = 1; dest_rob = 11; rd_rob = 10; val_rob = 32'h55;
    valid_iss = 1; rd_iss = 4; dest_iss = 3; rs1 = 10; rs2 = 1;
    cyc("flush", 4'd0, 32'h55, 4'd9, 32'h7);

    rs1 = 10; rs2 = 4;
    cyc("flush_x10_x4", 4'd0, 32'h55, 4'd0, 32'h0);

    rs1 = 1; rs2 = 2;
    cyc("flush_x1_x2", 4'd0, 32'h7, 4'd0, 32'h0);

    rs1 = 7; rs2 = 8;
    cyc("flush_x7_x8", 4'd0, 32'h9, 4'd0, 32'hABC);

    // Reset must win over a low rdy.
    rst = 1; rdy = 0; rs1 = 8; rs2 = 3;
    cyc("pre_rst", 4'd0, 32'hABC, 4'd0, 32'h1234);

    rs1 = 8; rs2 = 1;
    cyc("post_rst", 4'd0, 32'h0, 4'd0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
